// File: rtl/sysreg_spr_ctrl_if.sv
// Request/strobe bundle between the execute stage, the exception unit,
// the SPR register and the SPR update controller.
interface sysreg_spr_ctrl_if #(
    parameter int N = 32
);
    logic         iEXE_WR_REQ;
    logic [N-1:0] iEXE_WR_DATA;
    logic         iEXE_ADJ_REQ;
    logic         iEXE_ADJ_DIR;
    logic [3:0]   iEXE_ADJ_CNT;
    logic         oEXE_BUSY;
    logic         iEXCEPT_REQ;
    logic [N-1:0] iEXCEPT_KSP;
    logic         oEXCEPT_ACK;
    logic         iEXRET_REQ;
    logic         oEXRET_ACK;
    logic [N-1:0] iSPR_INFO_DATA;
    logic         oSPR_REGIST_REQ;
    logic [N-1:0] oSPR_REGIST_DATA;
    logic [N-1:0] oSAVED_SPR;
    logic         oADJ_WRAP;

    // Requesters and the SPR register side
    modport master (
        output iEXE_WR_REQ, iEXE_WR_DATA, iEXE_ADJ_REQ, iEXE_ADJ_DIR, iEXE_ADJ_CNT,
        output iEXCEPT_REQ, iEXCEPT_KSP, iEXRET_REQ, iSPR_INFO_DATA,
        input  oEXE_BUSY, oEXCEPT_ACK, oEXRET_ACK, oSPR_REGIST_REQ,
        input  oSPR_REGIST_DATA, oSAVED_SPR, oADJ_WRAP
    );

    modport slave (
        input  iEXE_WR_REQ, iEXE_WR_DATA, iEXE_ADJ_REQ, iEXE_ADJ_DIR, iEXE_ADJ_CNT,
        input  iEXCEPT_REQ, iEXCEPT_KSP, iEXRET_REQ, iSPR_INFO_DATA,
        output oEXE_BUSY, oEXCEPT_ACK, oEXRET_ACK, oSPR_REGIST_REQ,
        output oSPR_REGIST_DATA, oSAVED_SPR, oADJ_WRAP
    );
endinterface

// File: rtl/sysreg_spr_ctrl.sv
// SPR update controller: arbitrates exception entry/return, direct writes and
// push/pop adjusts onto the single SPR write port, keeping a pre-exception shadow.
module sysreg_spr_ctrl #(
    parameter int N    = 32,
    parameter int STEP = 4
) (
    input logic              iCLOCK,
    input logic              inRESET,
    sysreg_spr_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXC_SAVE = 2'd1,
        EXC_LOAD = 2'd2,
        RET_LOAD = 2'd3
    } ctrlState_t;

    ctrlState_t   state;
    ctrlState_t   stateNext;

    logic [N-1:0] kspLatch;
    logic [N-1:0] kspNext;
    logic [N-1:0] shadow;
    logic [N-1:0] shadowNext;
    logic         regReq;
    logic         regReqNext;
    logic [N-1:0] regData;
    logic [N-1:0] regDataNext;
    logic         excAck;
    logic         excAckNext;
    logic         retAck;
    logic         retAckNext;
    logic         adjWrap;
    logic         adjWrapNext;

    logic [N-1:0] base;
    logic [N-1:0] delta;
    logic [N:0]   adjResult;

    // A strobe still in flight has not reached the SPR yet, so forward it.
    assign base      = regReq ? regData : bus.iSPR_INFO_DATA;
    assign delta     = N'(bus.iEXE_ADJ_CNT) * N'(STEP);
    assign adjResult = bus.iEXE_ADJ_DIR ? ({1'b0, base} - {1'b0, delta})
                                        : ({1'b0, base} + {1'b0, delta});

    assign bus.oEXE_BUSY        = (state != IDLE) | bus.iEXCEPT_REQ | bus.iEXRET_REQ;
    assign bus.oEXCEPT_ACK      = excAck;
    assign bus.oEXRET_ACK       = retAck;
    assign bus.oSPR_REGIST_REQ  = regReq;
    assign bus.oSPR_REGIST_DATA = regData;
    assign bus.oSAVED_SPR       = shadow;
    assign bus.oADJ_WRAP        = adjWrap;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state    <= IDLE;
            kspLatch <= '0;
            shadow   <= '0;
            regReq   <= 1'b0;
            regData  <= '0;
            excAck   <= 1'b0;
            retAck   <= 1'b0;
            adjWrap  <= 1'b0;
        end else begin
            state    <= stateNext;
            kspLatch <= kspNext;
            shadow   <= shadowNext;
            regReq   <= regReqNext;
            regData  <= regDataNext;
            excAck   <= excAckNext;
            retAck   <= retAckNext;
            adjWrap  <= adjWrapNext;
        end
    end

    // Fixed priority in IDLE: exception > return > direct write > adjust.
    always_comb begin
        stateNext   = state;
        kspNext     = kspLatch;
        shadowNext  = shadow;
        regReqNext  = 1'b0;
        regDataNext = regData;
        excAckNext  = 1'b0;
        retAckNext  = 1'b0;
        adjWrapNext = 1'b0;

        case (state)
            IDLE: begin
                if (bus.iEXCEPT_REQ) begin
                    kspNext   = bus.iEXCEPT_KSP;
                    stateNext = EXC_SAVE;
                end else if (bus.iEXRET_REQ) begin
                    stateNext = RET_LOAD;
                end else if (bus.iEXE_WR_REQ) begin
                    regReqNext  = 1'b1;
                    regDataNext = bus.iEXE_WR_DATA;
                end else if (bus.iEXE_ADJ_REQ && (bus.iEXE_ADJ_CNT != 4'd0)) begin
                    regReqNext  = 1'b1;
                    regDataNext = adjResult[N-1:0];
                    adjWrapNext = adjResult[N];
                end
            end
            EXC_SAVE: begin
                shadowNext = base;
                stateNext  = EXC_LOAD;
            end
            EXC_LOAD: begin
                regReqNext  = 1'b1;
                regDataNext = kspLatch;
                excAckNext  = 1'b1;
                stateNext   = IDLE;
            end
            RET_LOAD: begin
                regReqNext  = 1'b1;
                regDataNext = shadow;
                retAckNext  = 1'b1;
                stateNext   = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Every acknowledge coincides with its regist strobe, and never both at once.
    ackHasStrobe: assert property (@(posedge iCLOCK) disable iff (!inRESET)
        (excAck || retAck) |-> regReq);
    acksExclusive: assert property (@(posedge iCLOCK) disable iff (!inRESET)
        !(excAck && retAck));

endmodule

// File: doc/sysreg_spr_ctrl.md
Name: sysreg_spr_ctrl

Overview:
Controller that sequences and arbitrates every update of the SPR (stack pointer) register in the execute stage.
- Shares the single SPR write port between four sources: exception entry, exception return, execute-stage direct write, and execute-stage push/pop adjust.
- Keeps a shadow copy of the pre-exception SPR.
- Drives the SPR register's regist request/data pair and reads back its info output.

Parameters:
N, 32, data width of SPR and all data ports
STEP, 4, byte increment per word for push/pop adjust

Ports:
iCLOCK  in  1  system clock
inRESET  in  1  reset, asynchronous, active-low
iEXE_WR_REQ  in  1  execute direct SPR write request (level, held until accepted)
iEXE_WR_DATA  in  N  direct write value
iEXE_ADJ_REQ  in  1  push/pop adjust request (level, held until accepted)
iEXE_ADJ_DIR  in  1  1=push (decrement), 0=pop (increment)
iEXE_ADJ_CNT  in  4  number of words to adjust
oEXE_BUSY  out  1  execute requests not accepted this cycle
iEXCEPT_REQ  in  1  exception entry request (level, held until ack)
iEXCEPT_KSP  in  N  kernel stack pointer to load on entry
oEXCEPT_ACK  out  1  one-cycle pulse, entry complete
iEXRET_REQ  in  1  exception return request (level, held until ack)
oEXRET_ACK  out  1  one-cycle pulse, return complete
iSPR_INFO_DATA  in  N  current SPR register value
oSPR_REGIST_REQ  out  1  SPR write strobe (registered)
oSPR_REGIST_DATA  out  N  SPR write value (registered)
oSAVED_SPR  out  N  shadow SPR saved at exception entry
oADJ_WRAP  out  1  one-cycle pulse, adjust wrapped modulo 2^N

Behaviour:
- Reset: all outputs 0, shadow 0, FSM in IDLE, latched KSP 0. Reset asserted mid-sequence aborts to IDLE; no ack is issued.
- FSM states: IDLE, EXC_SAVE, EXC_LOAD, RET_LOAD.
- Arbitration in IDLE, fixed priority: iEXCEPT_REQ > iEXRET_REQ > iEXE_WR_REQ > iEXE_ADJ_REQ. Exactly one request is accepted per cycle.
- oEXE_BUSY = (state != IDLE) | iEXCEPT_REQ | iEXRET_REQ. This is combinational.
- Execute requests are accepted only in cycles where oEXE_BUSY=0. A losing execute request stays pending with no side effect.
- Base value: if oSPR_REGIST_REQ=1 in the current cycle, base = oSPR_REGIST_DATA; otherwise base = iSPR_INFO_DATA. This forwards a write that has not yet landed, so back-to-back updates are correct.
- Exception entry:
  - IDLE + iEXCEPT_REQ: latch iEXCEPT_KSP, go to EXC_SAVE.
  - EXC_SAVE: shadow <= base, go to EXC_LOAD.
  - EXC_LOAD: oSPR_REGIST_REQ/DATA <= 1/KSP next edge, oEXCEPT_ACK pulses on that same edge, go to IDLE.
  - Ack is high 3 cycles after the request is first sampled in IDLE.
- Exception return:
  - IDLE + iEXRET_REQ: go to RET_LOAD.
  - RET_LOAD: regist shadow, pulse oEXRET_ACK, go to IDLE.
  - Ack is high 2 cycles after the request is sampled.
  - The shadow is not cleared by a return.
- Direct write: accepted in IDLE. Next edge: oSPR_REGIST_REQ=1, oSPR_REGIST_DATA=iEXE_WR_DATA.
- Adjust: delta = iEXE_ADJ_CNT*STEP, zero-extended to N bits.
  - Push: base - delta. Pop: base + delta. Both computed modulo 2^N.
  - oADJ_WRAP pulses together with the regist strobe on borrow (push) or carry (pop).
  - CNT=0: the request is accepted, with no regist strobe and no wrap.
- Strobes: oSPR_REGIST_REQ, oEXCEPT_ACK, oEXRET_ACK and oADJ_WRAP are single-cycle and registered. oSPR_REGIST_DATA holds its last value when REQ=0.
- Exception and exret requests arriving while the FSM is not in IDLE wait. A new exception request is arbitrated on the first IDLE cycle after the previous ack.

Test Plan:
1. Reset, then direct write 0x0000_1000 -> REGIST_REQ=1, DATA=0x1000 one cycle after accept; all other outputs 0.
2. SPR=0x1000, push CNT=3, then next cycle pop CNT=1 -> writes 0x0FF4 then 0x0FF8 via the forwarding path; no wrap.
3. SPR=0x0000_0004, push CNT=2 -> DATA=0xFFFF_FFFC, oADJ_WRAP pulse. SPR=0xFFFF_FFF8, pop CNT=4 -> DATA=0x0000_0008, wrap pulse.
4. SPR=0x2000, exception with KSP=0x8000_0000 -> shadow=0x2000, REGIST DATA=0x8000_0000, ACK 3 cycles after request. Exret -> DATA=0x2000, ACK after 2 cycles.
5. Exception, exret-blocked, direct write and adjust all asserted in the same cycle -> exception serviced first, oEXE_BUSY=1 throughout. Write then adjust are applied in later cycles; final value is correct.
6. Assert inRESET during EXC_LOAD -> no ack, no strobe, FSM IDLE, shadow 0.
